ddr_rx_align: RTL and testbench

- Sits directly downstream of the single-lane DDR input register.
- Each clock it takes the rising/falling sample pair, builds a 16-bit serial history, and finds byte and bit alignment from a repeated training word (SYNC).
- Once locked, it emits one aligned byte every 4 clocks with a 1-cycle valid strobe, for the framing/FIFO logic that follows.

---
 rtl/ddr_rx_align.sv | 134 +++++++++++++
 tb/tb_ddr_rx_align.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rx_align.sv
// ddr_rx_align: byte/bit aligner for a single-lane DDR receiver.
// Hunts for a repeated training byte in the serial history, confirms it at
// consecutive word boundaries, then emits one aligned byte every 4 clocks.
module ddr_rx_align #(
  parameter logic [7:0] SYNC       = 8'hB8,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic [1:0] d,
  input  logic       resync,
  output logic [7:0] q,
  output logic       valid,
  output logic       is_sync,
  output logic       locked,
  output logic       phase,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  // Only the newest nine history bits feed the two candidate windows.
  logic [8:0] sr;
  logic [1:0] cnt;
  logic [3:0] mcnt;
  state_t     state;

  logic [7:0] w0;
  logic [7:0] w1;
  logic [7:0] w_sel;
  logic       boundary;
  logic       verify_fail;

  // Candidate windows, the window picked by the locked phase, and the
  // cycle on which a VERIFY check fails (the error counter watches this).
  always_comb begin
    w0          = sr[7:0];
    w1          = sr[8:1];
    w_sel       = phase ? w1 : w0;
    boundary    = (cnt == 2'd3);
    verify_fail = 1'b0;
    if (!resync && (state == VERIFY) && boundary && (w_sel != SYNC)) begin
      verify_fail = 1'b1;
    end
  end

  // Serial history: earlier sample first, so the newest bit lands in sr[0].
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[6:0], d[0], d[1]};
    end
  end

  // Failed verifications, saturating; only reset clears it.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (verify_fail && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // Alignment FSM with the word counter, match counter and registered outputs.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      cnt     <= '0;
      mcnt    <= '0;
      phase   <= 1'b0;
      q       <= '0;
      valid   <= 1'b0;
      is_sync <= 1'b0;
      locked  <= 1'b0;
    end else begin
      cnt     <= cnt + 2'd1;
      valid   <= 1'b0;
      is_sync <= 1'b0;
      if (resync) begin
        state  <= HUNT;
        locked <= 1'b0;
        mcnt   <= '0;
      end else begin
        case (state)
          HUNT: begin
            if (w0 == SYNC) begin
              phase <= 1'b0;
              cnt   <= '0;
              mcnt  <= 4'd1;
              state <= VERIFY;
            end else if (w1 == SYNC) begin
              phase <= 1'b1;
              cnt   <= '0;
              mcnt  <= 4'd1;
              state <= VERIFY;
            end
          end
          VERIFY: begin
            if (boundary) begin
              if (w_sel == SYNC) begin
                mcnt <= mcnt + 4'd1;
                if ((mcnt + 4'd1) == LOCK_CNT) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                state <= HUNT;
                mcnt  <= '0;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              q       <= w_sel;
              valid   <= 1'b1;
              is_sync <= (w_sel == SYNC);
            end
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_rx_align.sv
// tb_ddr_rx_align: randomized and directed checks of ddr_rx_align against
// a bit-history reference model that tracks word boundaries by edge arithmetic.
module tb_ddr_rx_align;

  localparam logic [7:0] SYNC       = 8'hB8;
  localparam int         LOCK_COUNT = 4;
  localparam int         M_HUNT     = 0;
  localparam int         M_VERIFY   = 1;
  localparam int         M_LOCKED   = 2;

  logic       c      = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] d      = 2'b00;
  logic       resync = 1'b0;
  logic [7:0] q;
  logic       valid;
  logic       is_sync;
  logic       locked;
  logic       phase;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  bit tx_q[$];
  bit hist[$];

  int         m_state;
  int         m_edge;
  int         m_anchor;
  int         m_matches;
  logic       m_phase;
  logic [7:0] e_q;
  logic       e_valid;
  logic       e_sync;
  logic       e_locked;
  int         e_err;

  ddr_rx_align #(
    .SYNC      (SYNC),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .c      (c),
    .rst_n  (rst_n),
    .d      (d),
    .resync (resync),
    .q      (q),
    .valid  (valid),
    .is_sync(is_sync),
    .locked (locked),
    .phase  (phase),
    .err_cnt(err_cnt)
  );

  // Free-running clock.
  always #5 c = ~c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pop_bit();
    if (tx_q.size() == 0) return 1'b0;
    return tx_q.pop_front();
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tx_q.push_back(b[i]);
  endtask

  // Byte formed by the 8 most recent received bits, skipping 'back' newest bits.
  function automatic logic [7:0] win(input int back);
    logic [7:0] w;
    int idx;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      idx = hist.size() - 1 - back - i;
      if (idx >= 0) w[i] = hist[idx];
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_state   = M_HUNT;
    m_edge    = 0;
    m_anchor  = 0;
    m_matches = 0;
    m_phase   = 1'b0;
    e_q       = '0;
    e_valid   = 1'b0;
    e_sync    = 1'b0;
    e_locked  = 1'b0;
    e_err     = 0;
  endtask

  task automatic model_step();
    logic [7:0] wsel;
    bit bnd;
    wsel = win(m_phase ? 1 : 0);
    bnd = (m_edge > m_anchor) && (((m_edge - m_anchor) % 4) == 0);
    e_valid = 1'b0;
    e_sync  = 1'b0;
    if (resync) begin
      m_state   = M_HUNT;
      e_locked  = 1'b0;
      m_matches = 0;
    end else if (m_state == M_HUNT) begin
      if (win(0) == SYNC || win(1) == SYNC) begin
        m_phase   = (win(0) == SYNC) ? 1'b0 : 1'b1;
        m_anchor  = m_edge;
        m_matches = 1;
        m_state   = M_VERIFY;
      end
    end else if (m_state == M_VERIFY) begin
      if (bnd) begin
        if (wsel == SYNC) begin
          m_matches++;
          if (m_matches == LOCK_COUNT) begin
            m_state  = M_LOCKED;
            e_locked = 1'b1;
          end
        end else begin
          m_state   = M_HUNT;
          m_matches = 0;
          if (e_err < 255) e_err++;
        end
      end
    end else if (bnd) begin
      e_q     = wsel;
      e_valid = 1'b1;
      e_sync  = (wsel == SYNC);
    end
    hist.push_back(d[0]);
    hist.push_back(d[1]);
    while (hist.size() > 16) void'(hist.pop_front());
    m_edge++;
  endtask

  task automatic check_output();
    chk("q", q, e_q);
    chk("valid", valid, e_valid);
    chk("is_sync", is_sync, e_sync);
    chk("locked", locked, e_locked);
    chk("phase", phase, m_phase);
    chk("err_cnt", err_cnt, e_err);
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge,
  // compare at the next falling edge.
  task automatic apply_stimulus(input logic rs);
    d[0]   = pop_bit();
    d[1]   = pop_bit();
    resync = rs;
    @(posedge c);
    model_step();
    @(negedge c);
    check_output();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    d      = 2'b00;
    resync = 1'b0;
    tx_q.delete();
    @(posedge c);
    @(negedge c);
    model_reset();
    chk("reset q", q, 8'h00);
    chk("reset valid", valid, 1'b0);
    chk("reset locked", locked, 1'b0);
    chk("reset err_cnt", err_cnt, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(input int budget, output int t);
    t = 0;
    while (!locked && t < budget) begin
      apply_stimulus(1'b0);
      t++;
    end
  endtask

  initial begin
    int t;
    int seen12;
    int seen34;
    int nval;
    logic [7:0] first_q;
    logic [7:0] b;
    int r;
    @(negedge c);

    // Idle line after reset.
    do_reset();
    for (int k = 0; k < 10; k++) apply_stimulus(1'b0);
    chk("idle q", q, 8'h00);
    chk("idle locked", locked, 1'b0);
    chk("idle err_cnt", err_cnt, 8'h00);
    chk("idle model state", m_state, M_HUNT);

    // Even-aligned training, data bytes, then a resync pulse mid-word.
    do_reset();
    for (int k = 0; k < 8; k++) push_byte(SYNC);
    push_byte(8'h12);
    push_byte(8'h34);
    for (int k = 0; k < 12; k++) push_byte(SYNC);
    wait_lock(40, t);
    chk("even lock tick", t, 17);
    chk("even lock tick model", e_locked, 1'b1);
    chk("even phase", phase, 1'b0);
    seen12  = -1;
    seen34  = -1;
    nval    = 0;
    first_q = 8'h00;
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(1'b0);
      if (valid) begin
        if (nval == 0) first_q = q;
        nval++;
        if (q == 8'h12) begin
          seen12 = k;
          chk("is_sync on 12", is_sync, 1'b0);
        end
        if (q == 8'h34) begin
          seen34 = k;
          chk("is_sync on 34", is_sync, 1'b0);
        end
      end
    end
    chk("first locked byte", first_q, SYNC);
    chk("12 to 34 spacing", seen34 - seen12, 4);
    chk("valid count in 40", nval, 10);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    chk("resync locked", locked, 1'b0);
    chk("resync valid", valid, 1'b0);
    wait_lock(40, t);
    chk("even relock", locked, 1'b1);
    chk("even relock phase", phase, 1'b0);

    // Odd-aligned training: one extra leading bit.
    do_reset();
    tx_q.push_back(1'b1);
    for (int k = 0; k < 16; k++) push_byte(SYNC);
    wait_lock(40, t);
    chk("odd lock tick", t, 18);
    chk("odd phase", phase, 1'b1);
    first_q = 8'h00;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0);
      if (valid) first_q = q;
    end
    chk("odd byte", first_q, SYNC);
    apply_stimulus(1'b1);
    wait_lock(40, t);
    chk("odd relock", locked, 1'b1);
    chk("odd relock phase", phase, 1'b1);

    // Corrupted verify then relock.
    do_reset();
    push_byte(SYNC);
    push_byte(SYNC);
    push_byte(8'hB9);
    for (int k = 0; k < 8; k++) push_byte(SYNC);
    for (int k = 0; k < 13; k++) apply_stimulus(1'b0);
    chk("corrupt err_cnt", err_cnt, 8'd1);
    chk("corrupt locked", locked, 1'b0);
    chk("corrupt model state", m_state, M_HUNT);
    wait_lock(40, t);
    chk("corrupt relock", locked, 1'b1);

    // Held resync suppresses matching.
    do_reset();
    for (int k = 0; k < 10; k++) push_byte(SYNC);
    for (int k = 0; k < 20; k++) apply_stimulus(1'b1);
    chk("held resync locked", locked, 1'b0);
    chk("held resync model matches", m_matches, 0);
    wait_lock(40, t);
    chk("after held resync lock", locked, 1'b1);

    // Randomized traffic: training bursts, random bytes, bit slips, resyncs.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (tx_q.size() < 4) begin
        r = $urandom_range(0, 9);
        if (r <= 3) begin
          for (int j = 0; j < LOCK_COUNT + 2; j++) push_byte(SYNC);
        end else if (r <= 7) begin
          b = 8'($urandom);
          push_byte(b);
        end else if (r == 8) begin
          tx_q.push_back(1'($urandom));
        end else begin
          b = SYNC ^ (8'h01 << $urandom_range(0, 7));
          push_byte(b);
        end
      end
      apply_stimulus($urandom_range(0, 99) == 0);
    end

    // Error counter saturation.
    do_reset();
    for (int k = 0; k < 260; k++) begin
      push_byte(SYNC);
      push_byte(8'h00);
      for (int j = 0; j < 8; j++) apply_stimulus(1'b0);
    end
    chk("err_cnt saturated", err_cnt, 8'd255);
    chk("err_cnt saturated model", e_err, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
